// File: rtl/fsm_seq_if.sv
// Sequencer handshake bundle: advance enable, decode inputs, state and strobes.
interface fsm_seq_if;
  logic       RDY;
  logic       ACC, ALU, CI, IMM, LD, W, ZP, ZPY;
  logic [2:0] STATE;
  logic [2:0] CYC;
  logic       SYNC, RW, IRLD, PCINC, ADLLD, ADHLD, IDXE, CIL;

  modport master (
    output RDY, ACC, ALU, CI, IMM, LD, W, ZP, ZPY,
    input  STATE, CYC, SYNC, RW, IRLD, PCINC, ADLLD, ADHLD, IDXE, CIL
  );

  modport slave (
    input  RDY, ACC, ALU, CI, IMM, LD, W, ZP, ZPY,
    output STATE, CYC, SYNC, RW, IRLD, PCINC, ADLLD, ADHLD, IDXE, CIL
  );
endinterface

// File: rtl/fsm_seq.sv
// Instruction cycle sequencer: walks fetch/decode/address/memory/execute states,
// gated by RDY, with decode flags latched when leaving DECODE.
module fsm_seq (
  input  logic [4:0]  LOGISIM_CLOCK_TREE_0,
  input  logic        RSTN,
  fsm_seq_if.slave    bus
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    ADDR_LO = 3'd2,
    ADDR_HI = 3'd3,
    IDX     = 3'd4,
    READ    = 3'd5,
    EXEC    = 3'd6,
    WRITE   = 3'd7
  } state_t;

  typedef struct packed {
    logic acc, alu, ci, imm, ld, w, zp, zpy;
  } flags_t;

  logic   clk;
  state_t state_q, state_d, nxt;
  state_t mem_st, eff_st;
  flags_t flags_q, flags_d, flags_in;
  logic [2:0] cyc_q, cyc_d;
  logic   rdy;

  assign clk = LOGISIM_CLOCK_TREE_0[4];
  assign rdy = bus.RDY;

  // Only the global clock bit drives logic; LD is latched but has no sequencing effect.
  logic unused_bits;
  assign unused_bits = ^{LOGISIM_CLOCK_TREE_0[3:0], flags_q.ld};

  assign flags_in = '{acc: bus.ACC, alu: bus.ALU, ci: bus.CI, imm: bus.IMM,
                      ld: bus.LD, w: bus.W, zp: bus.ZP, zpy: bus.ZPY};

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q <= FETCH;
      cyc_q   <= 3'd0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    flags_d = flags_q;
    mem_st  = (flags_q.w && !flags_q.alu) ? WRITE : READ;
    nxt     = FETCH;
    case (state_q)
      FETCH:   nxt = DECODE;
      // Flags are not latched yet, so decode from the live inputs.
      DECODE:  nxt = (bus.IMM || bus.ACC) ? EXEC : ADDR_LO;
      ADDR_LO: nxt = !flags_q.zp ? ADDR_HI : (flags_q.zpy ? IDX : mem_st);
      ADDR_HI: nxt = mem_st;
      IDX:     nxt = mem_st;
      READ:    nxt = flags_q.alu ? EXEC : FETCH;
      EXEC:    nxt = (flags_q.w && flags_q.alu && !flags_q.imm && !flags_q.acc)
                     ? WRITE : FETCH;
      WRITE:   nxt = FETCH;
      default: nxt = FETCH;
    endcase
    if (rdy) begin
      state_d = nxt;
      cyc_d   = (nxt == FETCH) ? 3'd0 : cyc_q + 3'd1;
      if (state_q == DECODE) flags_d = flags_in;
    end
  end

  // While reset is held the outputs already present the FETCH view.
  always_comb begin
    eff_st    = RSTN ? state_q : FETCH;
    bus.STATE = state_q;
    bus.CYC   = cyc_q;
    bus.SYNC  = (eff_st == FETCH);
    bus.RW    = (eff_st != WRITE);
    bus.IRLD  = rdy && (eff_st == FETCH);
    bus.PCINC = rdy && ((eff_st == FETCH) || (eff_st == ADDR_LO) || (eff_st == ADDR_HI) ||
                        ((eff_st == EXEC) && flags_q.imm));
    bus.ADLLD = rdy && (eff_st == ADDR_LO);
    bus.ADHLD = rdy && (eff_st == ADDR_HI);
    bus.IDXE  = rdy && (eff_st == IDX);
    bus.CIL   = rdy && (eff_st == EXEC) && flags_q.ci;
  end

endmodule

// File: tb/tb_fsm_seq.sv
// Bench for fsm_seq: path-list model checked every cycle, plus literal trace checks.
module tb_fsm_seq;

  localparam logic [7:0] F_ACC = 8'h80, F_ALU = 8'h40, F_CI = 8'h20, F_IMM = 8'h10,
                         F_LD  = 8'h08, F_W   = 8'h04, F_ZP = 8'h02, F_ZPY = 8'h01;

  logic [4:0] tree;
  logic       clk;
  logic       rstn;
  fsm_seq_if  bus();

  assign clk = tree[4];

  fsm_seq dut (
    .LOGISIM_CLOCK_TREE_0 (tree),
    .RSTN                 (rstn),
    .bus                  (bus.slave)
  );

  initial tree = 5'd0;
  always #5 tree[4] = ~tree[4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_f(input logic [7:0] f);
    {bus.ACC, bus.ALU, bus.CI, bus.IMM, bus.LD, bus.W, bus.ZP, bus.ZPY} = f;
  endtask

  // Model: an instruction is a list of states; position in the list is the cycle count.
  int         m_seq[$] = '{0, 1};
  int         m_idx = 0;
  logic [7:0] m_f = 8'h00;

  task automatic build_path(input logic [7:0] f);
    m_seq = '{0, 1};
    if ((f & (F_IMM | F_ACC)) != 0) m_seq.push_back(6);
    else begin
      m_seq.push_back(2);
      if ((f & F_ZP) == 0)       m_seq.push_back(3);
      else if ((f & F_ZPY) != 0) m_seq.push_back(4);
      if ((f & F_W) != 0 && (f & F_ALU) == 0) m_seq.push_back(7);
      else begin
        m_seq.push_back(5);
        if ((f & F_ALU) != 0) begin
          m_seq.push_back(6);
          if ((f & F_W) != 0) m_seq.push_back(7);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      m_idx = 0;
      m_seq = '{0, 1};
      m_f   = 8'h00;
    end else if (bus.RDY) begin
      if (m_idx == 1) begin
        m_f = {bus.ACC, bus.ALU, bus.CI, bus.IMM, bus.LD, bus.W, bus.ZP, bus.ZPY};
        build_path(m_f);
      end
      m_idx++;
      if (m_idx >= m_seq.size()) begin
        m_idx = 0;
        m_seq = '{0, 1};
      end
    end
  end

  logic chk_en = 1'b0;
  logic tr_en  = 1'b0;
  int   tr_st[$], tr_cyc[$], tr_rw[$], tr_stb[$], tr_pc[$], tr_cil[$], tr_idx[$];
  int   e;
  logic r;
  logic [7:0] exp_o, act_o;

  always @(negedge clk) begin
    if (chk_en && rstn) begin
      e = m_seq[m_idx];
      r = bus.RDY;
      exp_o = {e == 0, e != 7, r && e == 0,
               r && (e == 0 || e == 2 || e == 3 || (e == 6 && m_f[4])),
               r && e == 2, r && e == 3, r && e == 4, r && e == 6 && m_f[5]};
      act_o = {bus.SYNC, bus.RW, bus.IRLD, bus.PCINC, bus.ADLLD, bus.ADHLD, bus.IDXE, bus.CIL};
      chk("state", 32'(bus.STATE), 32'(e));
      chk("cyc",   32'(bus.CYC),   32'(m_idx));
      chk("outs",  32'(act_o),     32'(exp_o));
    end
    if (tr_en) begin
      tr_st.push_back(int'(bus.STATE));
      tr_cyc.push_back(int'(bus.CYC));
      tr_rw.push_back(int'(bus.RW));
      tr_stb.push_back(int'(bus.IRLD | bus.PCINC | bus.ADLLD | bus.ADHLD | bus.IDXE | bus.CIL));
      tr_pc.push_back(int'(bus.PCINC));
      tr_cil.push_back(int'(bus.CIL));
      tr_idx.push_back(int'(bus.IDXE));
    end
  end

  function automatic logic [31:0] pk(input int q[$], input int sh);
    logic [31:0] v = 0;
    foreach (q[i]) v = (v << sh) | 32'(q[i]);
    return v;
  endfunction

  // Runs one instruction from FETCH; optional stall of st_n cycles at step st_at with
  // alternative decode inputs driven during the stall. Inputs are scrambled after DECODE.
  task automatic instr(input logic [7:0] f, input int len, input int st_at,
                       input int st_n, input logic [7:0] alt);
    set_f(f);
    bus.RDY = 1'b1;
    tr_st.delete(); tr_cyc.delete(); tr_rw.delete(); tr_stb.delete();
    tr_pc.delete(); tr_cil.delete(); tr_idx.delete();
    tr_en = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k == 2) set_f(~f);
      if (k == st_at) begin
        bus.RDY = 1'b0;
        if (k < 2) set_f(alt);
        repeat (st_n) begin @(posedge clk); #2; end
        bus.RDY = 1'b1;
        if (k < 2) set_f(f);
      end
      @(posedge clk); #2;
    end
    tr_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.RDY = 1'b0;
    set_f(8'h00);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_state", 32'(bus.STATE), 0);
    chk("rst_cyc",   32'(bus.CYC),   0);
    chk("rst_outs_rdy0", 32'({bus.SYNC, bus.RW, bus.IRLD, bus.PCINC, bus.ADLLD,
                              bus.ADHLD, bus.IDXE, bus.CIL}), 32'h0C0);
    bus.RDY = 1'b1;
    #1;
    chk("rst_outs_rdy1", 32'({bus.SYNC, bus.RW, bus.IRLD, bus.PCINC, bus.ADLLD,
                              bus.ADHLD, bus.IDXE, bus.CIL}), 32'h0F0);
    @(posedge clk); #2;
    rstn   = 1'b1;
    chk_en = 1'b1;

    // Immediate with carry-in
    instr(F_IMM | F_CI, 3, -1, 0, 8'h00);
    chk("imm_states", pk(tr_st, 3), 'o016);
    chk("imm_cyc",    pk(tr_cyc, 3), 'o012);
    chk("imm_pcinc",  pk(tr_pc, 1), 3'b101);
    chk("imm_cil",    pk(tr_cil, 1), 3'b001);
    chk("imm_back",   32'(bus.STATE), 0);

    instr(F_ACC | F_CI, 3, -1, 0, 8'h00);
    chk("acc_states", pk(tr_st, 3), 'o016);
    chk("acc_pcinc",  pk(tr_pc, 1), 3'b100);

    instr(F_ZP | F_LD, 4, -1, 0, 8'h00);
    chk("zp_states", pk(tr_st, 3), 'o0125);

    instr(F_ZP | F_ZPY | F_LD, 5, -1, 0, 8'h00);
    chk("zpy_states", pk(tr_st, 3), 'o01245);
    chk("zpy_idxe",   pk(tr_idx, 1), 5'b00010);
    chk("zpy_rw",     pk(tr_rw, 1), 5'b11111);

    instr(F_LD, 5, -1, 0, 8'h00);
    chk("abs_ld_states", pk(tr_st, 3), 'o01235);

    instr(8'h00, 5, -1, 0, 8'h00);
    chk("nop_states", pk(tr_st, 3), 'o01235);

    instr(F_ALU, 6, 2, 2, 8'h00);
    chk("alu_stall_states", pk(tr_st, 3), 'o01222356);

    instr(F_ALU | F_W, 7, -1, 0, 8'h00);
    chk("rmw_states", pk(tr_st, 3), 'o0123567);
    chk("rmw_rw",     pk(tr_rw, 1), 7'b1111110);
    chk("rmw_cyc",    pk(tr_cyc, 3), 'o0123456);

    // Write held for three stalled cycles
    instr(F_W, 5, 4, 3, 8'h00);
    chk("wr_stall_states", pk(tr_st, 3), 'o01237777);
    chk("wr_stall_rw",     pk(tr_rw, 1), 8'b11110000);
    chk("wr_stall_stb",    pk(tr_stb, 1), 8'b10110000);
    chk("wr_stall_back",   32'(bus.STATE), 0);

    // Decode inputs wiggled while DECODE is stalled must not matter
    instr(F_ZP | F_LD, 4, 1, 2, F_IMM | F_ACC);
    chk("dec_hold_states", pk(tr_st, 3), 'o011125);

    // Reset in the middle of an instruction
    instr(F_ALU | F_LD | F_CI, 4, 4, 0, 8'h00);
    chk("mid_read", 32'(bus.STATE), 5);
    rstn = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_state", 32'(bus.STATE), 0);
    chk("mid_rst_cyc",   32'(bus.CYC),   0);
    chk("mid_rst_cil",   32'(bus.CIL),   0);
    rstn = 1'b1;
    set_f(F_IMM);
    @(posedge clk); #2;
    chk("post_rst_decode", 32'(bus.STATE), 1);
    repeat (3) begin @(posedge clk); #2; end
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq.md
FSM_SEQ -- requirements
Module: fsm_seq

Interface
REQ-001 SHALL have ports: LOGISIM_CLOCK_TREE_0  in  5  clock tree; only bit [4] (global clock) is used, all logic on its rising edge, other bits unconnected.
REQ-002 SHALL have: RSTN  in  1  reset; synchronous, active-low.
REQ-003 SHALL have: RDY  in  1  advance enable; low freezes the sequencer.
REQ-004 SHALL have decode inputs, 1 bit each, driven by fsm_next_sig:
- ACC: accumulator mode.
- ALU: ALU operation.
- CI: carry-in.
- IMM: immediate.
- LD: load.
- W: memory write.
- ZP: zero page.
- ZPY: zero page indexed.
REQ-005 SHALL have: STATE  out  3  current state code.
REQ-006 SHALL have: SYNC  out  1  opcode fetch cycle.
REQ-007 SHALL have: RW  out  1  1 = read, 0 = write.
REQ-008 SHALL have these 1-bit strobes: IRLD (load IR), PCINC (increment PC), ADLLD (load address low), ADHLD (load address high), IDXE (index add), CIL (carry-in to ALU).
REQ-009 SHALL have: CYC  out  3  cycle count within the current instruction.

Function
REQ-010 State codes SHALL be: FETCH=0, DECODE=1, ADDR_LO=2, ADDR_HI=3, IDX=4, READ=5, EXEC=6, WRITE=7; STATE is a register.
REQ-011 State SHALL change only on a clock edge with RDY=1; with RDY=0, STATE, CYC and the flag register hold, and all strobes (IRLD, PCINC, ADLLD, ADHLD, IDXE, CIL) are 0.
REQ-012 Decode inputs SHALL be sampled into an internal flag register only on the DECODE->next transition; at all other times the inputs are ignored.
REQ-013 Transitions SHALL be as follows.
- FETCH->DECODE.
- DECODE->EXEC if IMM, else EXEC if ACC, else ADDR_LO; priority IMM > ACC.
- ADDR_LO->IDX if ZP&ZPY, ->MEM if ZP&!ZPY, else ->ADDR_HI.
- ADDR_HI->MEM; IDX->MEM.
- MEM = WRITE if W&!ALU, else READ.
- READ->EXEC if ALU, else FETCH.
- EXEC->WRITE if W&ALU&!IMM&!ACC, else FETCH.
- WRITE->FETCH.
REQ-014 Outputs SHALL be Moore functions of STATE and flags, with strobes ANDed with RDY:
- SYNC = FETCH.
- RW = 0 only in WRITE.
- IRLD = FETCH.
- PCINC = FETCH, ADDR_LO, ADDR_HI, or EXEC with IMM flag.
- ADLLD = ADDR_LO.
- ADHLD = ADDR_HI.
- IDXE = IDX.
- CIL = EXEC & latched CI.
REQ-015 CYC SHALL be 0 in FETCH and increment by 1 on each advancing transition; it returns to 0 on entry to FETCH and never wraps, since the maximum reachable value is 6.
REQ-016 Instruction lengths in cycles (FETCH through the last state) SHALL be:
- IMM: 3.
- ACC: 3.
- ZP LD: 4.
- ZPY LD: 5.
- Absolute LD: 5.
- Absolute W: 5.
- Absolute ALU: 6.
- Absolute read-modify-write (ALU&W): 7.
REQ-017 Flags with no memory or register effect (all decode inputs 0, non-ZP) SHALL follow the absolute read path of 5 cycles and then return to FETCH.
REQ-018 RDY low during WRITE SHALL hold RW=0 for every stalled cycle.

Reset
REQ-019 RSTN=0 at a clock edge SHALL force STATE=FETCH, CYC=0 and flags=0 regardless of RDY or the current state, including mid-instruction.
REQ-020 Output values during and immediately after reset SHALL be: SYNC=1, RW=1, ADLLD=ADHLD=IDXE=CIL=0, IRLD=PCINC=RDY.
REQ-021 The first advancing edge after RSTN rises SHALL move to DECODE.

Verification
REQ-022 IMM=1, CI=1, RDY=1 -> STATE 0,1,6,0; PCINC=1 in 0 and 6; CIL=1 only in 6; CYC 0,1,2,0.
REQ-023 ZP=ZPY=LD=1 -> STATE 0,1,2,4,5,0; IDXE=1 only in 4; RW=1 throughout.
REQ-024 ALU=W=1, ZP=0 -> STATE 0,1,2,3,5,6,7,0; RW=0 only in 7; CYC reaches 6.
REQ-025 W=1, ALU=0, with RDY=0 for 3 cycles in WRITE -> STATE holds 7, RW=0 for all 3 cycles, strobes 0; FETCH follows the first RDY=1 edge.
REQ-026 RSTN=0 while STATE=5 -> next edge STATE=0, CYC=0, CIL=0; decode inputs changed during DECODE hold are ignored until the transition edge.
